// File: rtl/switch_bounce_gen.sv
// Switch-bounce emulator: turns a clean requested level into a bouncy
// switch waveform (first contact, LFSR-paced chatter, then a stable level).
module switch_bounce_gen #(
    parameter int          TICK_M       = 50_000,
    parameter int          BOUNCE_TICKS = 8,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic clk,
    input  logic reset,
    input  logic level_in,
    output logic sw_out,
    output logic busy,
    output logic done
);

    localparam int TW = $clog2(TICK_M);
    localparam int BW = $clog2(BOUNCE_TICKS + 1);

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_M - 1);
    localparam logic [BW-1:0] BNC_LAST  = BW'(BOUNCE_TICKS - 1);

    // An all-zero Galois LFSR would lock up, so a zero seed is replaced.
    localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [15:0] MASK = 16'hB400;

    typedef enum logic {
        IDLE,
        BOUNCE
    } state_t;

    state_t        state, state_nx;
    logic          stable_level, stable_level_nx;
    logic          target, target_nx;
    logic [TW-1:0] tick_cnt, tick_cnt_nx;
    logic [BW-1:0] bnc_cnt, bnc_cnt_nx;
    logic [15:0]   lfsr, lfsr_nx;
    logic          sw_out_nx;
    logic          done_nx;

    logic          tick;
    logic [15:0]   lfsr_step;

    assign busy      = (state == BOUNCE);
    assign tick      = (state == BOUNCE) && (tick_cnt == TICK_LAST);
    assign lfsr_step = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? MASK : 16'h0000);

    // State register and all datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            stable_level <= 1'b0;
            target       <= 1'b0;
            tick_cnt     <= '0;
            bnc_cnt      <= '0;
            lfsr         <= SEED;
            sw_out       <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_nx;
            stable_level <= stable_level_nx;
            target       <= target_nx;
            tick_cnt     <= tick_cnt_nx;
            bnc_cnt      <= bnc_cnt_nx;
            lfsr         <= lfsr_nx;
            sw_out       <= sw_out_nx;
            done         <= done_nx;
        end
    end

    // Next-state and next-output logic; a level change restarts the window
    // and wins over a coincident tick.
    always_comb begin
        state_nx        = state;
        stable_level_nx = stable_level;
        target_nx       = target;
        tick_cnt_nx     = '0;
        bnc_cnt_nx      = bnc_cnt;
        lfsr_nx         = lfsr;
        sw_out_nx       = sw_out;
        done_nx         = 1'b0;

        unique case (state)
            IDLE: begin
                sw_out_nx = stable_level;
                if (level_in != stable_level) begin
                    target_nx  = level_in;
                    sw_out_nx  = level_in;
                    bnc_cnt_nx = '0;
                    state_nx   = BOUNCE;
                end
            end
            BOUNCE: begin
                tick_cnt_nx = tick ? '0 : tick_cnt + 1'b1;
                if (level_in != target) begin
                    target_nx   = level_in;
                    sw_out_nx   = level_in;
                    tick_cnt_nx = '0;
                    bnc_cnt_nx  = '0;
                end else if (tick && (bnc_cnt < BNC_LAST)) begin
                    sw_out_nx  = lfsr[0];
                    lfsr_nx    = lfsr_step;
                    bnc_cnt_nx = bnc_cnt + 1'b1;
                end else if (tick) begin
                    sw_out_nx       = target;
                    stable_level_nx = target;
                    done_nx         = 1'b1;
                    state_nx        = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule
